// File: rtl/water_inlet_pkg.sv
// Shared types for the water-inlet arbiter: FSM state encoding and counter sizing.
package water_inlet_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      GAP   = 2'b10
   } arb_state_e;

   function automatic int cnt_width(input int fill_cycles, input int gap_cycles);
      int longest;
      longest = (fill_cycles > gap_cycles) ? fill_cycles : gap_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] rr_ptr,
   output logic [N-1:0]  winner,
   output logic [PW-1:0] winner_idx,
   output logic          valid
);

   logic [PW-1:0] idx_k;

   always_comb begin
      winner     = '0;
      winner_idx = '0;
      valid      = 1'b0;
      idx_k      = '0;
      for (int k = 0; k < N; k++) begin
         idx_k = PW'((int'(rr_ptr) + k) % N);
         if (!valid && req[idx_k]) begin
            valid         = 1'b1;
            winner_idx    = idx_k;
            winner[idx_k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/water_inlet_arbiter.sv
// Round-robin owner of the shared water-inlet valve; optional priority class
// enabled by defining WATER_INLET_ARB_PRIO_EN.
//   state | meaning
//   IDLE  | valve closed, arbitrating among fill_req
//   GRANT | valve open for the owner, counting down the fill
//   GAP   | valve closed, settle time before the next arbitration
module water_inlet_arbiter
   import water_inlet_pkg::*;
#(
   parameter int NUM_MACHINES = 4,
   parameter int FILL_CYCLES  = 10,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_MACHINES-1:0] fill_req,
   input  logic [NUM_MACHINES-1:0] hi_prio,
   output logic [NUM_MACHINES-1:0] grant,
   output logic                    valve_open,
   output logic [NUM_MACHINES-1:0] fill_done,
   output logic                    fill_abort,
   output logic                    busy
);

   localparam int PW = $clog2(NUM_MACHINES);
   localparam int CW = cnt_width(FILL_CYCLES, GAP_CYCLES);
   localparam logic [CW-1:0] FILL_LOAD = CW'(FILL_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
   localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_MACHINES - 1);

   arb_state_e              state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [PW-1:0]           owner_q, owner_d;
   logic [NUM_MACHINES-1:0] grant_d, done_d;
   logic                    abort_d;
   logic [NUM_MACHINES-1:0] pick_onehot;
   logic [PW-1:0]           pick_idx;
   logic                    pick_valid;
   logic                    owner_req;
   logic [PW-1:0]           ptr_after_owner;

`ifdef WATER_INLET_ARB_PRIO_EN
   logic [NUM_MACHINES-1:0] hi_onehot, all_onehot;
   logic [PW-1:0]           hi_idx, all_idx;
   logic                    hi_valid, all_valid;

   rr_pick #(.N(NUM_MACHINES), .PW(PW)) u_pick_hi (
      .req(fill_req & hi_prio), .rr_ptr(ptr_q),
      .winner(hi_onehot), .winner_idx(hi_idx), .valid(hi_valid)
   );
   rr_pick #(.N(NUM_MACHINES), .PW(PW)) u_pick_all (
      .req(fill_req), .rr_ptr(ptr_q),
      .winner(all_onehot), .winner_idx(all_idx), .valid(all_valid)
   );

   // A high-priority requester, when present, shadows everyone else.
   assign pick_onehot = hi_valid ? hi_onehot : all_onehot;
   assign pick_idx    = hi_valid ? hi_idx    : all_idx;
   assign pick_valid  = hi_valid | all_valid;
`else
   logic unused_hi_prio;
   assign unused_hi_prio = ^hi_prio;

   rr_pick #(.N(NUM_MACHINES), .PW(PW)) u_pick_all (
      .req(fill_req), .rr_ptr(ptr_q),
      .winner(pick_onehot), .winner_idx(pick_idx), .valid(pick_valid)
   );
`endif

   assign owner_req       = |(fill_req & grant);
   assign ptr_after_owner = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      grant_d = grant;
      done_d  = '0;
      abort_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_onehot;
               owner_d = pick_idx;
               cnt_d   = FILL_LOAD;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // A dropped request wins over completion, even on the final cycle.
            if (!owner_req || cnt_q == '0) begin
               grant_d = '0;
               cnt_d   = GAP_LOAD;
               ptr_d   = ptr_after_owner;
               state_d = GAP;
               if (owner_req) done_d  = grant;
               else           abort_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ptr_q      <= '0;
         owner_q    <= '0;
         grant      <= '0;
         valve_open <= 1'b0;
         fill_done  <= '0;
         fill_abort <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         grant      <= grant_d;
         valve_open <= |grant_d;
         fill_done  <= done_d;
         fill_abort <= abort_d;
         busy       <= (state_d != IDLE);
      end
   end

endmodule
